// File: rtl/rx_frame_ctrl.sv
// Framed UART receive sequencer: HEADER, LEN, PAYLOAD[LEN], CSUM -> payload strobes plus frame status.
// Outputs registered, 1 cycle after the byte event; no backpressure, pl_valid is a strobe the consumer must take.
module rx_frame_ctrl #(
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_en,
  output logic        rx_en_sig,
  input  logic        rx_done_sig,
  input  logic [7:0]  rx_data,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pl_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] CODE_ABORT = 2'd0;
  localparam logic [1:0] CODE_TMO   = 2'd1;
  localparam logic [1:0] CODE_LEN   = 2'd2;
  localparam logic [1:0] CODE_CSUM  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN, S_PAY, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          done_q;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    pl_data_q, pl_data_d;
  logic          pl_valid_q, pl_valid_d;
  logic          pl_last_q, pl_last_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          busy_q, busy_d;
  logic          rx_en_q, rx_en_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic byte_ev;
  logic timed;
  logic tmo_hit;

  // Edge detect makes a level-style done count as a single byte.
  assign byte_ev = rx_done_sig & ~done_q;
  assign timed   = (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CSUM);
  assign tmo_hit = timed && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    pl_data_d  = pl_data_q;
    pl_valid_d = 1'b0;
    pl_last_d  = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    tmo_d      = (!timed || byte_ev) ? '0 : tmo_q + TW'(1);

    if (!ctrl_en) begin
      state_d = S_IDLE;
      if (timed) begin
        err_d  = 1'b1;
        code_d = CODE_ABORT;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_HDR;
        S_HDR: begin
          if (byte_ev && rx_data == HEADER) state_d = S_LEN;
        end
        S_LEN: begin
          if (byte_ev) begin
            len_d = rx_data;
            sum_d = rx_data;
            cnt_d = 8'd0;
            if (rx_data == 8'd0) begin
              state_d = S_CSUM;
            end else if (rx_data > 8'(MAX_LEN)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
              code_d  = CODE_LEN;
            end else begin
              state_d = S_PAY;
            end
          end else if (tmo_hit) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = CODE_TMO;
          end
        end
        S_PAY: begin
          if (byte_ev) begin
            pl_data_d  = rx_data;
            pl_valid_d = 1'b1;
            sum_d      = sum_q + rx_data;
            cnt_d      = cnt_q + 8'd1;
            if (cnt_q == len_q - 8'd1) begin
              pl_last_d = 1'b1;
              state_d   = S_CSUM;
            end
          end else if (tmo_hit) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = CODE_TMO;
          end
        end
        S_CSUM: begin
          if (byte_ev) begin
            if (rx_data == sum_q) begin
              state_d = S_DONE;
              ok_d    = 1'b1;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
              code_d  = CODE_CSUM;
            end
          end else if (tmo_hit) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = CODE_TMO;
          end
        end
        S_DONE:  state_d = S_HDR;
        S_ERR:   state_d = S_HDR;
        default: state_d = S_IDLE;
      endcase
    end

    frame_cnt_d = ok_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    err_cnt_d   = (err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    // The DONE/ERR cycle drops rx_en for one cycle to re-arm the receiver.
    rx_en_d = (state_d == S_HDR) || (state_d == S_LEN) || (state_d == S_PAY) || (state_d == S_CSUM);
    busy_d  = (state_d == S_LEN) || (state_d == S_PAY) || (state_d == S_CSUM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      cnt_q       <= 8'd0;
      tmo_q       <= '0;
      pl_data_q   <= 8'd0;
      pl_valid_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'd0;
      busy_q      <= 1'b0;
      rx_en_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      done_q      <= rx_done_sig;
      len_q       <= len_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pl_last_q   <= pl_last_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      code_q      <= code_d;
      busy_q      <= busy_d;
      rx_en_q     <= rx_en_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_en_sig = rx_en_q;
  assign pl_data   = pl_data_q;
  assign pl_valid  = pl_valid_q;
  assign pl_last   = pl_last_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: table of frames, hand-timed corner sequences, random frames against a stream parser.
module tb_rx_frame_ctrl;
  localparam int MAXL = 16;
  localparam int TMO  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrl_en = 1'b0;
  logic        rx_done_sig = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_en_sig;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_last;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  rx_frame_ctrl #(.HEADER(8'hAA), .MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .rx_en_sig(rx_en_sig),
    .rx_done_sig(rx_done_sig), .rx_data(rx_data), .pl_data(pl_data),
    .pl_valid(pl_valid), .pl_last(pl_last), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code), .busy(busy),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Output monitor: running totals, sampled on the falling edge.
  int         mon_pl = 0, mon_last = 0, mon_ok = 0, mon_err = 0;
  logic [7:0] mon_last_dat = 8'h00;
  logic [7:0] mon_arr [4096];

  always @(negedge clk) begin
    if (pl_valid) begin
      if (mon_pl < 4096) mon_arr[mon_pl] <= pl_data;
      mon_pl <= mon_pl + 1;
      if (pl_last) begin
        mon_last     <= mon_last + 1;
        mon_last_dat <= pl_data;
      end
    end
    if (frame_ok)  mon_ok  <= mon_ok + 1;
    if (frame_err) mon_err <= mon_err + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b, input int w, input int g);
    rx_data     = b;
    rx_done_sig = 1'b1;
    repeat (w) tick();
    rx_done_sig = 1'b0;
    repeat (g) tick();
  endtask

  typedef struct {
    logic [15:0] noise;
    int          n_noise;
    logic [7:0]  len;
    logic [7:0]  p0;
    logic [7:0]  step;
    logic [7:0]  adj;
    int          exp_pl;
    logic [7:0]  exp_last;
    int          exp_ok;
    int          exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vt [10];

  int exp_fc = 0;
  int exp_ec = 0;

  initial begin
    logic [7:0] b, sum;
    int pl0, ok0, er0, la0, k_seen;
    logic [7:0] sq [$];
    logic [7:0] ep [$];
    int m_ok, m_err, m_last;
    logic [1:0] m_code;

    vt[0] = '{16'h0000, 0, 8'h03, 8'h11, 8'h11, 8'h00,  3, 8'h33, 1, 0, 2'd0};
    vt[1] = '{16'h0000, 0, 8'h03, 8'h11, 8'h11, 8'hFF,  3, 8'h33, 0, 1, 2'd3};
    vt[2] = '{16'h5500, 2, 8'h00, 8'h00, 8'h00, 8'h00,  0, 8'h00, 1, 0, 2'd0};
    vt[3] = '{16'h0000, 0, 8'h11, 8'h00, 8'h00, 8'h00,  0, 8'h00, 0, 1, 2'd2};
    vt[4] = '{16'h0000, 0, 8'h10, 8'h01, 8'h01, 8'h00, 16, 8'h10, 1, 0, 2'd0};
    vt[5] = '{16'h0000, 0, 8'h01, 8'hFF, 8'h00, 8'h00,  1, 8'hFF, 1, 0, 2'd0};
    vt[6] = '{16'h0000, 0, 8'hAA, 8'h00, 8'h00, 8'h00,  0, 8'h00, 0, 1, 2'd2};
    vt[7] = '{16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h01,  0, 8'h00, 0, 1, 2'd3};
    vt[8] = '{16'h0000, 0, 8'h02, 8'hAA, 8'h00, 8'h00,  2, 8'hAA, 1, 0, 2'd0};
    vt[9] = '{16'h3C00, 1, 8'hFF, 8'h00, 8'h00, 8'h00,  0, 8'h00, 0, 1, 2'd2};

    // Reset state
    repeat (3) tick();
    chk("reset_outputs", {rx_en_sig, pl_data, pl_valid, pl_last, frame_ok, frame_err,
                          err_code, busy, frame_cnt, err_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_rxen", rx_en_sig, 1'b0);
    ctrl_en = 1'b1;
    tick();
    chk("hdr_rxen", rx_en_sig, 1'b1);
    chk("hdr_busy", busy, 1'b0);

    // Good frame with exact completion timing
    pl0 = mon_pl;
    put_byte(8'hAA, 1, 1);
    put_byte(8'h03, 1, 1);
    put_byte(8'h11, 2, 1);
    put_byte(8'h22, 1, 1);
    put_byte(8'h33, 1, 1);
    chk("csum_busy", busy, 1'b1);
    rx_data = 8'h69; rx_done_sig = 1'b1;
    tick();
    rx_done_sig = 1'b0;
    chk("ok_latency", frame_ok, 1'b1);
    chk("ok_frame_cnt", frame_cnt, 16'd1);
    chk("done_rxen_drop", rx_en_sig, 1'b0);
    tick();
    chk("ok_width", frame_ok, 1'b0);
    chk("rxen_rearm", rx_en_sig, 1'b1);
    chk("good_pl_count", mon_pl - pl0, 3);
    chk("good_pl_last", mon_last_dat, 8'h33);
    exp_fc = 1;

    // Table of frames
    for (int i = 0; i < 10; i++) begin
      pl0 = mon_pl; ok0 = mon_ok; er0 = mon_err; la0 = mon_last;
      for (int j = 0; j < vt[i].n_noise; j++)
        put_byte(j == 0 ? vt[i].noise[15:8] : vt[i].noise[7:0], 1 + (i % 3), 2);
      put_byte(8'hAA, 1 + (i % 3), 1);
      put_byte(vt[i].len, 1, 1 + (i % 2));
      if (int'(vt[i].len) <= MAXL) begin
        sum = vt[i].len;
        for (int k = 0; k < int'(vt[i].len); k++) begin
          b = vt[i].p0 + 8'(k) * vt[i].step;
          sum = sum + b;
          put_byte(b, 1 + (k % 2), 1);
        end
        put_byte(sum + vt[i].adj, 1, 4);
      end else begin
        repeat (4) tick();
      end
      exp_fc += vt[i].exp_ok;
      exp_ec += vt[i].exp_err;
      chk($sformatf("vec%0d_pl", i), mon_pl - pl0, vt[i].exp_pl);
      chk($sformatf("vec%0d_last_cnt", i), mon_last - la0, (vt[i].exp_pl > 0) ? 1 : 0);
      if (vt[i].exp_pl > 0) chk($sformatf("vec%0d_last_dat", i), mon_last_dat, vt[i].exp_last);
      chk($sformatf("vec%0d_ok", i), mon_ok - ok0, vt[i].exp_ok);
      chk($sformatf("vec%0d_err", i), mon_err - er0, vt[i].exp_err);
      if (vt[i].exp_err > 0) chk($sformatf("vec%0d_code", i), err_code, vt[i].exp_code);
      chk($sformatf("vec%0d_frame_cnt", i), frame_cnt, 16'(exp_fc));
      chk($sformatf("vec%0d_err_cnt", i), err_cnt, 16'(exp_ec));
    end

    // Inter-byte timeout
    put_byte(8'hAA, 1, 1);
    put_byte(8'h02, 1, 1);
    rx_data = 8'h11; rx_done_sig = 1'b1;
    tick();
    rx_done_sig = 1'b0;
    k_seen = -1;
    for (int k = 1; k <= TMO + 50; k++) begin
      tick();
      if (frame_err) begin
        k_seen = k;
        break;
      end
    end
    exp_ec++;
    chk("tmo_latency", k_seen, TMO);
    chk("tmo_code", err_code, 2'd1);
    chk("tmo_err_cnt", err_cnt, 16'(exp_ec));
    chk("tmo_rxen_drop", rx_en_sig, 1'b0);
    tick();
    chk("tmo_err_width", frame_err, 1'b0);
    chk("tmo_rxen_rearm", rx_en_sig, 1'b1);

    // Synchronous reset mid-frame
    put_byte(8'hAA, 1, 1);
    put_byte(8'h03, 1, 1);
    put_byte(8'h11, 1, 0);
    rst_n = 1'b0;
    tick();
    chk("midframe_reset", {rx_en_sig, pl_data, pl_valid, pl_last, frame_ok, frame_err,
                           err_code, busy, frame_cnt, err_cnt}, 64'd0);
    rst_n = 1'b1;
    exp_fc = 0; exp_ec = 0;
    tick();
    chk("post_reset_rxen", rx_en_sig, 1'b1);

    // ctrl_en drop colliding with a payload byte
    put_byte(8'hAA, 1, 1);
    put_byte(8'h03, 1, 1);
    put_byte(8'h11, 1, 1);
    pl0 = mon_pl;
    rx_data = 8'h22; rx_done_sig = 1'b1; ctrl_en = 1'b0;
    tick();
    rx_done_sig = 1'b0;
    exp_ec++;
    chk("abort_no_plv", pl_valid, 1'b0);
    chk("abort_err", frame_err, 1'b1);
    chk("abort_code", err_code, 2'd0);
    chk("abort_rxen", rx_en_sig, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_err_cnt", err_cnt, 16'(exp_ec));
    tick();
    tick();
    chk("abort_err_width", frame_err, 1'b0);
    chk("abort_idle_rxen", rx_en_sig, 1'b0);
    chk("abort_pl_count", mon_pl - pl0, 0);
    ctrl_en = 1'b1;
    tick();
    chk("abort_rearm", rx_en_sig, 1'b1);

    // Random frames, pulse or level done, against a stream parser
    for (int f = 0; f < 40; f++) begin
      int nn, len, kind;
      logic [7:0] s;
      nn = $urandom_range(0, 2);
      for (int j = 0; j < nn; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hAA) b = 8'h55;
        sq.push_back(b);
      end
      sq.push_back(8'hAA);
      kind = $urandom_range(0, 9);
      len = (kind == 0) ? $urandom_range(MAXL + 1, 255) : $urandom_range(0, MAXL);
      sq.push_back(8'(len));
      if (len <= MAXL) begin
        s = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          s = s + b;
          sq.push_back(b);
        end
        if (kind >= 7) s = s + 8'($urandom_range(1, 255));
        sq.push_back(s);
      end
    end
    pl0 = mon_pl; ok0 = mon_ok; er0 = mon_err; la0 = mon_last;
    foreach (sq[i]) put_byte(sq[i], $urandom_range(1, 3), $urandom_range(1, 3));
    repeat (6) tick();

    m_ok = 0; m_err = 0; m_last = 0; m_code = 2'd0;
    begin
      int i, n, len;
      logic [7:0] s;
      i = 0;
      n = sq.size();
      while (i < n) begin
        if (sq[i] != 8'hAA) begin
          i++;
        end else begin
          len = int'(sq[i + 1]);
          if (len > MAXL) begin
            m_err++; m_code = 2'd2;
            i += 2;
          end else begin
            s = 8'(len);
            for (int k = 0; k < len; k++) begin
              ep.push_back(sq[i + 2 + k]);
              s = s + sq[i + 2 + k];
            end
            if (len > 0) m_last++;
            if (sq[i + 2 + len] == s) m_ok++;
            else begin
              m_err++; m_code = 2'd3;
            end
            i += 3 + len;
          end
        end
      end
    end
    chk("rnd_pl_count", mon_pl - pl0, ep.size());
    foreach (ep[i])
      if (pl0 + i < 4096) chk($sformatf("rnd_pl_%0d", i), mon_arr[pl0 + i], ep[i]);
    chk("rnd_last_count", mon_last - la0, m_last);
    chk("rnd_ok", mon_ok - ok0, m_ok);
    chk("rnd_err", mon_err - er0, m_err);
    chk("rnd_code", err_code, m_code);
    chk("rnd_frame_cnt", frame_cnt, 16'(exp_fc + m_ok));
    chk("rnd_err_cnt", err_cnt, 16'(exp_ec + m_err));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
